// File: rtl/auction_round_ctrl.sv
// Bid-side controller for one auction round: collects one bid per bidder, feeds the
// argmax array, waits out its latency, then offers a one-hot award over valid/ready.
module auction_round_ctrl #(
  parameter int bW         = 17,
  parameter int N          = 10,
  parameter int ARGMAX_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bid_valid_i,
  output logic                 bid_ready_o,
  input  logic [3:0]           bid_id_i,
  input  logic [bW-1:0]        bid_value_i,
  input  logic                 round_abort_i,
  output logic [N-1:0][bW-1:0] bids_o,
  input  logic [3:0]           win_in_i,
  output logic                 award_valid_o,
  input  logic                 award_ready_i,
  output logic [3:0]           award_idx_o,
  output logic [bW-1:0]        award_value_o,
  output logic [N-1:0]         award_grant_o,
  output logic                 round_busy_o,
  output logic [7:0]           round_cnt_o,
  output logic                 err_bid_o
);
  localparam int CW = (ARGMAX_LAT < 2) ? 1 : $clog2(ARGMAX_LAT + 1);

  typedef enum logic [1:0] {COLLECT, WAIT, AWARD} state_e;

  state_e          state_q;
  logic [N-1:0]    seen_q, seen_d;
  logic [CW-1:0]   cnt_q;
  logic            bid_ready_q, award_valid_q, round_busy_q, err_bid_q;
  logic [3:0]      award_idx_q;
  logic [bW-1:0]   award_value_q;
  logic [N-1:0]    award_grant_q;
  logic [7:0]      round_cnt_q;

  logic               accept, id_ok, new_ok, win_ok, ld_bid, clr_bids, award_hs;
  logic [15:0]        seen_pad;
  logic [15:0][bW-1:0] bids_pad;

  // Padded views keep 4-bit indices in range for any N up to 16.
  always_comb begin
    bids_pad = '0;
    for (int i = 0; i < N; i++) bids_pad[i] = bids_o[i];
  end
  assign seen_pad = 16'(seen_q);

  assign accept   = bid_valid_i & bid_ready_q;
  assign id_ok    = {1'b0, bid_id_i} < 5'(N);
  assign new_ok   = id_ok & ~seen_pad[bid_id_i];
  assign seen_d   = seen_q | (N'(1) << bid_id_i);
  assign win_ok   = {1'b0, win_in_i} < 5'(N);
  assign award_hs = (state_q == AWARD) & award_ready_i;
  assign ld_bid   = accept & new_ok & ~round_abort_i;
  assign clr_bids = round_abort_i | award_hs;

  for (genvar g = 0; g < N; g++) begin : g_slot
    logic [bW-1:0] slot_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                             slot_q <= '0;
      else if (clr_bids)                       slot_q <= '0;
      else if (ld_bid && bid_id_i == 4'(g))    slot_q <= bid_value_i;
    end
    assign bids_o[g] = slot_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= COLLECT;
      seen_q        <= '0;
      cnt_q         <= '0;
      bid_ready_q   <= 1'b0;
      award_valid_q <= 1'b0;
      award_idx_q   <= '0;
      award_value_q <= '0;
      award_grant_q <= '0;
      round_busy_q  <= 1'b0;
      round_cnt_q   <= '0;
      err_bid_q     <= 1'b0;
    end else begin
      err_bid_q <= 1'b0;
      if (round_abort_i) begin
        // Abort wins over any bid or award handshake in the same cycle.
        state_q       <= COLLECT;
        seen_q        <= '0;
        bid_ready_q   <= 1'b1;
        award_valid_q <= 1'b0;
        award_grant_q <= '0;
        round_busy_q  <= 1'b0;
      end else begin
        case (state_q)
          COLLECT: begin
            bid_ready_q <= 1'b1;
            if (accept) begin
              if (new_ok) begin
                seen_q <= seen_d;
                if (&seen_d) begin
                  state_q      <= WAIT;
                  cnt_q        <= CW'(ARGMAX_LAT);
                  bid_ready_q  <= 1'b0;
                  round_busy_q <= 1'b1;
                end
              end else begin
                err_bid_q <= 1'b1;
              end
            end
          end
          WAIT: begin
            if (cnt_q == '0) begin
              award_idx_q   <= win_in_i;
              award_value_q <= win_ok ? bids_pad[win_in_i] : '0;
              award_grant_q <= win_ok ? (N'(1) << win_in_i) : '0;
              award_valid_q <= 1'b1;
              state_q       <= AWARD;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          AWARD: begin
            if (award_ready_i) begin
              award_valid_q <= 1'b0;
              award_grant_q <= '0;
              seen_q        <= '0;
              round_cnt_q   <= round_cnt_q + 8'd1;
              state_q       <= COLLECT;
              bid_ready_q   <= 1'b1;
              round_busy_q  <= 1'b0;
            end
          end
          default: state_q <= COLLECT;
        endcase
      end
    end
  end

  assign bid_ready_o   = bid_ready_q;
  assign award_valid_o = award_valid_q;
  assign award_idx_o   = award_idx_q;
  assign award_value_o = award_value_q;
  assign award_grant_o = award_grant_q;
  assign round_busy_o  = round_busy_q;
  assign round_cnt_o   = round_cnt_q;
  assign err_bid_o     = err_bid_q;
endmodule

// File: tb/tb_auction_round_ctrl.sv
// Bench for auction_round_ctrl: behavioural argmax feeds win_in, expected awards go
// through a scoreboard queue and are popped when award_valid rises.
module tb_auction_round_ctrl;
  localparam int bW = 17, N = 10, LAT = 1;

  logic                 clk = 1'b0, rst_n = 1'b0;
  logic                 bid_valid = 1'b0, bid_ready;
  logic [3:0]           bid_id = '0;
  logic [bW-1:0]        bid_value = '0;
  logic                 round_abort = 1'b0;
  logic [N-1:0][bW-1:0] bids;
  logic [3:0]           win_in, win_model = '0;
  logic                 fault_en = 1'b0;
  logic                 award_valid, award_ready = 1'b0;
  logic [3:0]           award_idx;
  logic [bW-1:0]        award_value;
  logic [N-1:0]         award_grant;
  logic                 round_busy, err_bid;
  logic [7:0]           round_cnt;

  auction_round_ctrl #(.bW(bW), .N(N), .ARGMAX_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bid_valid_i(bid_valid), .bid_ready_o(bid_ready),
    .bid_id_i(bid_id), .bid_value_i(bid_value), .round_abort_i(round_abort),
    .bids_o(bids), .win_in_i(win_in), .award_valid_o(award_valid),
    .award_ready_i(award_ready), .award_idx_o(award_idx), .award_value_o(award_value),
    .award_grant_o(award_grant), .round_busy_o(round_busy), .round_cnt_o(round_cnt),
    .err_bid_o(err_bid));

  always #5 clk = ~clk;

  // Argmax stand-in: one registered stage, ties resolved toward the highest index.
  function automatic logic [3:0] amax(input logic [N-1:0][bW-1:0] b);
    int best = 0;
    for (int i = 1; i < N; i++) if (b[i] >= b[best]) best = i;
    return 4'(best);
  endfunction
  always @(posedge clk) win_model <= amax(bids);
  assign win_in = fault_en ? 4'd12 : win_model;

  typedef struct { logic [3:0] idx; logic [bW-1:0] val; logic [N-1:0] grant; } exp_t;
  exp_t sb[$];
  int   exp_bids[N];
  int   n_chk = 0, n_pass = 0, err_cnt = 0;

  always @(negedge clk) if (err_bid === 1'b1) err_cnt++;

  function automatic exp_t model_award();
    exp_t e;
    int best = 0;
    for (int i = 1; i < N; i++) if (exp_bids[i] >= exp_bids[best]) best = i;
    e.idx = 4'(best);
    e.val = bW'(exp_bids[best]);
    e.grant = '0;
    e.grant[best] = 1'b1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bid(input int id, input int val);
    bit acc = 0;
    int g = 0;
    bid_valid = 1'b1; bid_id = 4'(id); bid_value = bW'(val);
    while (!acc && g < 20) begin acc = bid_ready; step(); g++; end
    bid_valid = 1'b0;
    if (!acc) begin n_chk++; $display("FAIL bid_accept: id %0d not accepted within 20 cycles", id); end
  endtask

  task automatic run_bids(input bit rev, input bit push);
    for (int k = 0; k < N; k++) begin
      int id = rev ? N - 1 - k : k;
      if (push && k == N - 1) sb.push_back(model_award());
      send_bid(id, exp_bids[id]);
    end
  endtask

  task automatic check_award(input string nm, input int exp_lat, output exp_t e);
    int lat = 0;
    e = '{default: '0};
    while (award_valid !== 1'b1 && lat < 50) begin step(); lat++; end
    n_chk++;
    if (award_valid !== 1'b1) begin $display("FAIL %s_valid: award_valid never rose", nm); return; end
    else n_pass++;
    n_chk++;
    if (sb.size() == 0) begin $display("FAIL %s_sb: award with empty scoreboard", nm); return; end
    else n_pass++;
    e = sb.pop_front();
    if (exp_lat >= 0) begin
      n_chk++; if (lat !== exp_lat) $display("FAIL %s_lat: got %0d want %0d", nm, lat, exp_lat); else n_pass++;
    end
    n_chk++; if (award_idx !== e.idx) $display("FAIL %s_idx: got %0d want %0d", nm, award_idx, e.idx); else n_pass++;
    n_chk++; if (award_value !== e.val) $display("FAIL %s_value: got %0d want %0d", nm, award_value, e.val); else n_pass++;
    n_chk++; if (award_grant !== e.grant) $display("FAIL %s_grant: got %b want %b", nm, award_grant, e.grant); else n_pass++;
    n_chk++; if ({round_busy, bid_ready} !== 2'b10) $display("FAIL %s_busy_rdy: got %b want 10", nm, {round_busy, bid_ready}); else n_pass++;
  endtask

  task automatic handshake(input string nm, input int exp_cnt);
    award_ready = 1'b1; step(); award_ready = 1'b0;
    n_chk++; if ({award_valid, award_grant} !== '0) $display("FAIL %s_clear: valid/grant got %b want 0", nm, {award_valid, award_grant}); else n_pass++;
    n_chk++; if (round_cnt !== 8'(exp_cnt)) $display("FAIL %s_cnt: got %0d want %0d", nm, round_cnt, exp_cnt); else n_pass++;
    n_chk++; if (bids !== '0) $display("FAIL %s_bids: got %h want 0", nm, bids); else n_pass++;
    n_chk++; if ({round_busy, bid_ready} !== 2'b01) $display("FAIL %s_busy_rdy: got %b want 01", nm, {round_busy, bid_ready}); else n_pass++;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if ({bid_ready, award_valid, award_idx, award_value, award_grant, round_busy, round_cnt, err_bid} !== '0)
      $display("FAIL reset_outputs: some output non-zero during reset"); else n_pass++;
    n_chk++; if (bids !== '0) $display("FAIL reset_bids: got %h want 0", bids); else n_pass++;
    step(); rst_n = 1'b1; #1;
    n_chk++; if (bid_ready !== 1'b0) $display("FAIL reset_rdy_first: got %b want 0", bid_ready); else n_pass++;
    step();
    n_chk++; if (bid_ready !== 1'b1) $display("FAIL reset_rdy_after: got %b want 1", bid_ready); else n_pass++;
  endtask

  task automatic test_ascending();
    exp_t e;
    for (int i = 0; i < N; i++) exp_bids[i] = 10 * (i + 1);
    run_bids(1'b0, 1'b1);
    check_award("asc", LAT + 1, e);
    n_chk++; if ({award_idx, award_value, award_grant} !== {4'd9, 17'd100, 10'b10_0000_0000})
      $display("FAIL asc_const: got idx %0d value %0d grant %b want 9 100 1000000000", award_idx, award_value, award_grant); else n_pass++;
    handshake("asc", 1);
  endtask

  task automatic test_equal_reverse();
    exp_t e;
    for (int i = 0; i < N; i++) exp_bids[i] = 'h64;
    run_bids(1'b1, 1'b1);
    check_award("eqrev", LAT + 1, e);
    handshake("eqrev", 2);
  endtask

  task automatic test_dup_bad_id();
    exp_t e;
    int e0 = err_cnt;
    for (int i = 0; i < N; i++) exp_bids[i] = $urandom_range(1, 131071);
    exp_bids[3] = 5;
    send_bid(3, 5);
    send_bid(3, 999);
    send_bid(12, 7);
    for (int i = 0; i < N - 1; i++) if (i != 3) send_bid(i, exp_bids[i]);
    n_chk++; if (round_busy !== 1'b0) $display("FAIL dup_early_busy: got %b want 0 after 9 valid", round_busy); else n_pass++;
    n_chk++; if (bids[3] !== 17'd5) $display("FAIL dup_bid3: got %0d want 5", bids[3]); else n_pass++;
    sb.push_back(model_award());
    send_bid(N - 1, exp_bids[N - 1]);
    n_chk++; if (round_busy !== 1'b1) $display("FAIL dup_busy: got %b want 1 after 10th valid", round_busy); else n_pass++;
    n_chk++; if (err_cnt - e0 !== 2) $display("FAIL dup_err_pulses: got %0d want 2", err_cnt - e0); else n_pass++;
    check_award("dup", LAT + 1, e);
    handshake("dup", 3);
  endtask

  task automatic test_award_stall();
    exp_t e;
    int bad = 0;
    for (int i = 0; i < N; i++) exp_bids[i] = $urandom_range(1, 131071);
    run_bids(1'b0, 1'b1);
    check_award("stall", LAT + 1, e);
    bid_valid = 1'b1; bid_id = 4'd0; bid_value = 17'd55;
    for (int c = 0; c < 20; c++) begin
      step();
      if (award_valid !== 1'b1 || award_idx !== e.idx || award_value !== e.val ||
          award_grant !== e.grant || bid_ready !== 1'b0) bad++;
    end
    bid_valid = 1'b0;
    n_chk++; if (bad !== 0) $display("FAIL stall_stable: %0d unstable cycles, want 0", bad); else n_pass++;
    n_chk++; if (bids[0] !== bW'(exp_bids[0])) $display("FAIL stall_bid0: got %0d want %0d", bids[0], exp_bids[0]); else n_pass++;
    handshake("stall", 4);
  endtask

  task automatic test_abort();
    exp_t e;
    int e0 = err_cnt;
    for (int i = 0; i < N; i++) exp_bids[i] = $urandom_range(1, 131071);
    for (int i = 0; i < 6; i++) send_bid(i, exp_bids[i]);
    round_abort = 1'b1; step(); round_abort = 1'b0;
    n_chk++; if (bids !== '0) $display("FAIL abort_bids: got %h want 0", bids); else n_pass++;
    n_chk++; if ({round_busy, bid_ready, round_cnt} !== {2'b01, 8'd4}) $display("FAIL abort_state: busy/rdy/cnt got %b want 01/4", {round_busy, bid_ready, round_cnt}); else n_pass++;
    run_bids(1'b0, 1'b1);
    check_award("abort_round", LAT + 1, e);
    n_chk++; if (err_cnt !== e0) $display("FAIL abort_err: got %0d pulses want 0", err_cnt - e0); else n_pass++;
    round_abort = 1'b1; award_ready = 1'b1; step(); round_abort = 1'b0; award_ready = 1'b0;
    n_chk++; if ({award_valid, award_grant} !== '0) $display("FAIL abort_award_clear: got %b want 0", {award_valid, award_grant}); else n_pass++;
    n_chk++; if (round_cnt !== 8'd4) $display("FAIL abort_cnt: got %0d want 4", round_cnt); else n_pass++;
    n_chk++; if ({round_busy, bid_ready} !== 2'b01 || bids !== '0) $display("FAIL abort_award_state: busy/rdy got %b bids %h", {round_busy, bid_ready}, bids); else n_pass++;
  endtask

  task automatic test_bad_win();
    exp_t e, f;
    for (int i = 0; i < N; i++) exp_bids[i] = 100 + i;
    fault_en = 1'b1;
    f.idx = 4'd12; f.val = '0; f.grant = '0;
    run_bids(1'b0, 1'b0);
    sb.push_back(f);
    check_award("badwin", LAT + 1, e);
    fault_en = 1'b0;
    handshake("badwin", 5);
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    for (int i = 0; i < N; i++) exp_bids[i] = $urandom_range(1, 131071);
    run_bids(1'b0, 1'b0);
    n_chk++; if (round_busy !== 1'b1) $display("FAIL rstwait_busy: got %b want 1", round_busy); else n_pass++;
    #2 rst_n = 1'b0; #1;
    n_chk++; if ({bid_ready, award_valid, award_grant, round_busy, round_cnt, err_bid} !== '0 || bids !== '0)
      $display("FAIL rstwait_async: outputs not at reset values without a clock edge"); else n_pass++;
    step(); rst_n = 1'b1; step();
    run_bids(1'b1, 1'b1);
    check_award("rstwait", LAT + 1, e);
    handshake("rstwait", 1);
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_equal_reverse();
    test_dup_bad_id();
    test_award_stall();
    test_abort();
    test_bad_win();
    test_reset_mid_wait();
    n_chk++; if (sb.size() !== 0) $display("FAIL sb_drain: %0d entries left", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/auction_round_ctrl.md
Name: auction_round_ctrl

Overview:
- Bid-side controller for one auction round: the producer of the argmax bid array and the consumer of its registered winner index.
- Accepts bids from N bidders one at a time over a valid/ready channel and holds them in a register array that drives the argmax `bids` input.
- Once every bidder has bid, it waits out the argmax latency, captures the winner index, and issues a one-hot award on a valid/ready award channel.
- Sits between the bidder interconnect and the argmax instance.

Parameters:
- bW, 17, bid value width in bits.
- N, 10, number of bidders; legal range 2..16.
- ARGMAX_LAT, 1, clock cycles from a stable `bids` array to a valid `win_in`.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bid_valid  input  1  bid beat offered.
- bid_ready  output  1  controller can accept a bid.
- bid_id  input  4  bidder index of the offered bid.
- bid_value  input  bW  bid amount, unsigned.
- round_abort  input  1  synchronous round cancel.
- bids  output  N x bW  bid array to the argmax.
- win_in  input  4  winner index from the argmax.
- award_valid  output  1  award pending.
- award_ready  input  1  award consumer accepts.
- award_idx  output  4  winning bidder index.
- award_value  output  bW  winning bid amount.
- award_grant  output  N  one-hot grant; bit award_idx is set while award_valid=1, otherwise all zeros.
- round_busy  output  1  high in the WAIT and AWARD states.
- round_cnt  output  8  number of completed rounds; wraps from 255 to 0.
- err_bid  output  1  one-cycle pulse when a bid is dropped.

Behaviour:
- Reset (asynchronous, rst_n=0) sets the following, and takes effect mid-operation in any state:
  - state=COLLECT, seen mask=0, bids all 0.
  - bid_ready=0 for the first cycle after reset deassertion, then 1.
  - award_valid=0, award_idx=0, award_value=0, award_grant=0.
  - round_busy=0, round_cnt=0, err_bid=0.
- COLLECT state:
  - bid_ready=1.
  - A beat is accepted on an edge where bid_valid & bid_ready.
  - If bid_id<N and seen[bid_id]=0: bids[bid_id] is loaded with bid_value and seen[bid_id] is set.
  - If bid_id>=N or seen[bid_id]=1: the beat is still consumed, bids and seen are unchanged, and err_bid pulses high for the next cycle.
  - When the accepted beat completes the seen mask (all N bits set), the next state is WAIT.
  - Arrival order of bids is arbitrary.
- WAIT state:
  - bid_ready=0 and bids are held stable.
  - A counter is loaded with ARGMAX_LAT on entry and decrements each cycle.
  - On the edge where the counter equals 0:
    - award_idx is loaded with win_in.
    - award_value is loaded with bids[win_in].
    - award_valid is set to 1 and the state moves to AWARD.
  - Net latency: award_valid rises ARGMAX_LAT+1 cycles after the edge that accepts the final bid (2 cycles at default).
- AWARD state:
  - award_valid, award_idx, award_value and award_grant hold stable until award_ready=1.
  - On the handshake edge:
    - award_valid=0 and award_grant=0.
    - seen=0 and bids cleared to 0.
    - round_cnt increments, wrapping 255 to 0.
    - The state moves to COLLECT.
  - bid_ready returns to 1 on the cycle after the handshake. A bid presented during AWARD is not accepted (no same-cycle pass-through).
- round_abort:
  - Sampled in every state and takes priority over bid acceptance and the award handshake in the same cycle.
  - On the edge it is seen: state=COLLECT, seen=0, bids=0, award_valid=0.
  - round_cnt is not incremented and no err_bid pulse is produced.
- Ties: the controller does not re-resolve ties; it trusts win_in. The argmax breaks ties in favour of the highest index, so all-equal bids yield index N-1.
- win_in >= N is treated as an argmax fault: award_idx=win_in, award_value=0, award_grant=0, award_valid still asserts.
- All outputs are driven directly from registers; no combinational path from inputs to outputs except bid_ready, which is state-derived only.

Test Plan:
- Bids id0..9 with values 10,20,...,100 presented back-to-back → award_valid rises 2 cycles after the 10th accept; award_idx=9, award_value=100, award_grant=10'b10_0000_0000; round_cnt=1 after award_ready.
- All ten bids = 17'h00064 in reverse id order → award_idx=9, award_value=100.
- Bid id3 sent twice (5 then 999), then id12, then the remaining ids → two err_bid pulses; bids[3]=5; the round completes after exactly 10 valid accepts.
- award_ready held low for 20 cycles → award outputs stable and bid_ready=0 throughout; bid_valid asserted during this time is not accepted.
- round_abort asserted after 6 bids, and again in AWARD together with award_ready → returns to COLLECT with seen=0 and award_valid=0; round_cnt unchanged.
- rst_n pulsed low asynchronously mid-WAIT → all outputs reach reset values without a clock edge; a subsequent full round completes normally with round_cnt=1.
